sdram_write: RTL and testbench
==============================

SDRAM_WRITE -- requirements
Module: sdram_write

Interface
REQ-001 SHALL be clocked by a single clock; reset is synchronous and active-high.
REQ-002 Parameter BASE_ADDR, default 32'h0: byte address of the first burst.
REQ-003 Parameter BURST_BYTES, default 64: bytes per burst; a multiple of 4, giving BURST_WORDS = BURST_BYTES/4.
REQ-004 Parameter REGION_BYTES, default 32'h0010_0000: size of the capture region; a multiple of BURST_BYTES.
REQ-005 Port clk  in  1: system clock.
REQ-006 Port reset  in  1: synchronous, active-high reset.
REQ-007 Port start_write  in  1: level; capture is requested while high.
REQ-008 Port sample_data  in  32: ADC sample word.
REQ-009 Port sample_valid  in  1: sample_data is valid this cycle; the source cannot stall.
REQ-010 Port sample_ready  out  1: the word is accepted this cycle when sample_valid is also high.
REQ-011 Port control_done  in  1: write master has finished the current transfer.
REQ-012 Port user_buffer_full  in  1: write-master FIFO is full.
REQ-013 Port control_fixed_location  out  1: tied to 0 (incrementing address).
REQ-014 Port control_write_base  out  32: current burst byte address.
REQ-015 Port control_write_length  out  32: constant BURST_BYTES.
REQ-016 Port control_go  out  1: one-cycle pulse that starts a burst.
REQ-017 Port user_write_buffer  out  1: write strobe into the master FIFO.
REQ-018 Port user_write_data  out  32: data presented with the strobe.
REQ-019 Port busy  out  1: high in any state other than IDLE.
REQ-020 Port overflow  out  1: sticky flag indicating a sample was dropped.
REQ-021 Port bursts_done  out  16: count of completed bursts; wraps at 65535 -> 0.

Function
REQ-022 SHALL implement FSM states IDLE, GO, STREAM, WAIT_DONE.
REQ-023 IDLE -> GO when start_write=1; otherwise remain in IDLE.
REQ-024 GO SHALL assert control_go for exactly one cycle, with control_write_base already stable; GO -> STREAM.
REQ-025 sample_ready = (state==STREAM) && !user_buffer_full && (word_cnt < BURST_WORDS).
REQ-026 On sample_valid && sample_ready, the next cycle SHALL have user_write_buffer=1 and user_write_data equal to the sampled word (1-cycle latency); word_cnt increments.
REQ-027 user_write_buffer SHALL be 0 in every other cycle.
REQ-028 When the accepted word makes word_cnt reach BURST_WORDS: STREAM -> WAIT_DONE, and word_cnt clears.
REQ-029 In WAIT_DONE on control_done=1:
  - base += BURST_BYTES; if the result is >= BASE_ADDR+REGION_BYTES, base wraps to BASE_ADDR;
  - bursts_done increments;
  - next state is GO if start_write=1, else IDLE.
REQ-030 control_done seen in any state other than WAIT_DONE SHALL be ignored.
REQ-031 sample_valid=1 in STREAM with user_buffer_full=1 SHALL drop the word and set overflow.
REQ-032 Samples presented in IDLE, GO or WAIT_DONE SHALL be discarded without setting overflow.
REQ-033 overflow SHALL clear only on reset or on the IDLE->GO transition.
REQ-034 start_write falling mid-burst SHALL NOT abort the burst: the burst completes and the FSM then returns to IDLE.
REQ-035 Address arithmetic SHALL be unsigned 32-bit; the burst base is never partially advanced.

Reset
REQ-036 On reset: state=IDLE, base=BASE_ADDR, word_cnt=0, bursts_done=0, overflow=0, control_go=0, user_write_buffer=0, user_write_data=0.
REQ-037 Reset asserted mid-burst SHALL abandon the burst at once with no further strobes; the master is re-armed only by a new GO.

Structure
REQ-038 A shared package sdram_pkg SHALL hold the FSM state encoding, BURST_BYTES/REGION_BYTES defaults and the address width, so the read and write paths share one definition.
REQ-039 No sub-module is required; the write-data register and strobe stay inline.

Verification
REQ-040 start_write=1 with 16 back-to-back samples 0..15 and full=0 -> one control_go pulse at base 0x0; strobes carry data 0..15; after done, base=0x40 and bursts_done=1.
REQ-041 user_buffer_full held for 3 cycles while samples stream -> sample_ready=0 for those cycles, 3 words dropped, overflow=1, and the burst still totals 16 strobes.
REQ-042 REGION_BYTES=128 with start_write held for 3 bursts -> control_write_base sequence is 0x0, 0x40, 0x0.
REQ-043 start_write dropped after 5 words -> the remaining 11 words are accepted, and after done the FSM is in IDLE with busy=0.
REQ-044 reset pulsed after word 7 -> no further strobes; all outputs hold their reset values; a new start begins again at base 0x0.
REQ-045 control_done pulsed in STREAM -> ignored; the burst completes and the address advances exactly once.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM capture read/write paths:
// FSM state encoding, burst/region defaults and address arithmetic.
package sdram_pkg;

    localparam int ADDR_W = 32;
    localparam int DEF_BURST_BYTES = 64;
    localparam logic [ADDR_W-1:0] DEF_REGION_BYTES = 32'h0010_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GO,
        ST_STREAM,
        ST_WAIT_DONE
    } sdram_state_t;

    // Advance a burst base by one step, wrapping to the region start.
    function automatic logic [ADDR_W-1:0] next_burst_base(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] step,
        input logic [ADDR_W-1:0] start,
        input logic [ADDR_W-1:0] limit
    );
        logic [ADDR_W-1:0] sum;
        sum = base + step;
        return (sum >= limit) ? start : sum;
    endfunction

endpackage

// File: rtl/sdram_write.sv
// Streams ADC samples into a DMA write master as fixed-size bursts
// over a wrapping capture region.
module sdram_write
    import sdram_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0,
    parameter int                BURST_BYTES  = DEF_BURST_BYTES,
    parameter logic [ADDR_W-1:0] REGION_BYTES = DEF_REGION_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_write,
    input  logic [31:0]       sample_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic              control_done,
    input  logic              user_buffer_full,
    output logic              control_fixed_location,
    output logic [ADDR_W-1:0] control_write_base,
    output logic [31:0]       control_write_length,
    output logic              control_go,
    output logic              user_write_buffer,
    output logic [31:0]       user_write_data,
    output logic              busy,
    output logic              overflow,
    output logic [15:0]       bursts_done
);

    localparam int BURST_WORDS = BURST_BYTES / 4;
    localparam int CNT_W = $clog2(BURST_WORDS + 1);
    localparam logic [CNT_W-1:0] WORDS = CNT_W'(BURST_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_WORDS - 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_BYTES);
    localparam logic [ADDR_W-1:0] LIMIT = BASE_ADDR + REGION_BYTES;

    sdram_state_t state, state_next;

    logic [CNT_W-1:0]  word_cnt;
    logic [ADDR_W-1:0] base;
    logic              accept;
    logic              last_word;
    logic              done_now;

    assign accept    = sample_valid && sample_ready;
    assign last_word = accept && (word_cnt == LAST_WORD);
    assign done_now  = (state == ST_WAIT_DONE) && control_done;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        sample_ready = 1'b0;
        control_go   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_write) state_next = ST_GO;
            end
            ST_GO: begin
                control_go = 1'b1;
                state_next = ST_STREAM;
            end
            ST_STREAM: begin
                sample_ready = !user_buffer_full && (word_cnt < WORDS);
                if (last_word) state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (control_done)
                    state_next = start_write ? ST_GO : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base              <= BASE_ADDR;
            word_cnt          <= '0;
            bursts_done       <= '0;
            overflow          <= 1'b0;
            user_write_buffer <= 1'b0;
            user_write_data   <= '0;
        end else begin
            user_write_buffer <= accept;
            if (accept) begin
                user_write_data <= sample_data;
                word_cnt        <= last_word ? '0 : word_cnt + 1'b1;
            end
            // Only a stalled STREAM loses data; other states just ignore it.
            if ((state == ST_STREAM) && sample_valid && user_buffer_full)
                overflow <= 1'b1;
            else if ((state == ST_IDLE) && start_write)
                overflow <= 1'b0;
            if (done_now) begin
                base        <= next_burst_base(base, STEP, BASE_ADDR, LIMIT);
                bursts_done <= bursts_done + 16'd1;
            end
        end
    end

    assign control_fixed_location = 1'b0;
    assign control_write_base     = base;
    assign control_write_length   = 32'(BURST_BYTES);
    assign busy                   = (state != ST_IDLE);

endmodule

// File: tb/tb_sdram_write.sv
// Directed self-checking bench for sdram_write with a 128-byte region
// so address wrap is reachable within a few bursts.
module tb_sdram_write;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_write;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        control_done;
    logic        user_buffer_full;
    logic        control_fixed_location;
    logic [31:0] control_write_base;
    logic [31:0] control_write_length;
    logic        control_go;
    logic        user_write_buffer;
    logic [31:0] user_write_data;
    logic        busy;
    logic        overflow;
    logic [15:0] bursts_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] go_q[$];

    sdram_write #(
        .BASE_ADDR   (32'h0),
        .BURST_BYTES (64),
        .REGION_BYTES(32'd128)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start_write           (start_write),
        .sample_data           (sample_data),
        .sample_valid          (sample_valid),
        .sample_ready          (sample_ready),
        .control_done          (control_done),
        .user_buffer_full      (user_buffer_full),
        .control_fixed_location(control_fixed_location),
        .control_write_base    (control_write_base),
        .control_write_length  (control_write_length),
        .control_go            (control_go),
        .user_write_buffer     (user_write_buffer),
        .user_write_data       (user_write_data),
        .busy                  (busy),
        .overflow              (overflow),
        .bursts_done           (bursts_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (user_write_buffer) got_q.push_back(user_write_data);
        if (control_go) go_q.push_back(control_write_base);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got_q.delete();
        exp_q.delete();
        go_q.delete();
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 20 && !sample_ready; k++) step();
        check("ready_timeout", 32'(sample_ready), 32'd1);
    endtask

    task automatic feed(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_data  = 32'(first + i);
            exp_q.push_back(32'(first + i));
            step();
        end
        sample_valid = 1'b0;
    endtask

    task automatic finish_burst();
        step();
        control_done = 1'b1;
        step();
        control_done = 1'b0;
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_data"}, got_q[i], exp_q[i]);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_go"}, 32'(control_go), 32'd0);
        check({tag, "_base"}, control_write_base, 32'h0);
        check({tag, "_bursts"}, 32'(bursts_done), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_wbuf"}, 32'(user_write_buffer), 32'd0);
        check({tag, "_wdata"}, user_write_data, 32'd0);
        check({tag, "_ready"}, 32'(sample_ready), 32'd0);
    endtask

    initial begin
        reset            = 1'b1;
        start_write      = 1'b0;
        sample_data      = '0;
        sample_valid     = 1'b0;
        control_done     = 1'b0;
        user_buffer_full = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        check_reset_state("rst");
        check("length", control_write_length, 32'd64);
        check("fixed", 32'(control_fixed_location), 32'd0);

        // One clean burst of 0..15.
        clear_logs();
        start_write = 1'b1;
        wait_ready();
        feed(16, 0);
        start_write = 1'b0;
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_ready", 32'(sample_ready), 32'd0);
        sample_valid = 1'b1;
        sample_data  = 32'hDEAD;
        step();
        sample_valid = 1'b0;
        check("wait_drop_ovf", 32'(overflow), 32'd0);
        finish_burst();
        step();
        check_stream("b1");
        check("b1_go_n", 32'(go_q.size()), 32'd1);
        check("b1_go_base", go_q[0], 32'h0);
        check("b1_base", control_write_base, 32'h40);
        check("b1_bursts", 32'(bursts_done), 32'd1);
        check("b1_busy", 32'(busy), 32'd0);

        // FIFO full for three cycles mid-stream.
        clear_logs();
        start_write = 1'b1;
        wait_ready();
        check("b2_go_base", go_q[0], 32'h40);
        for (int c = 0; c < 19; c++) begin
            user_buffer_full = (c >= 4 && c < 7);
            sample_valid     = 1'b1;
            sample_data      = 32'(100 + c);
            #1;
            check("b2_ready", 32'(sample_ready), 32'(!user_buffer_full));
            if (!user_buffer_full) exp_q.push_back(32'(100 + c));
            @(posedge clk);
            #1;
        end
        sample_valid     = 1'b0;
        user_buffer_full = 1'b0;
        start_write      = 1'b0;
        check("b2_ovf", 32'(overflow), 32'd1);
        finish_burst();
        step();
        check_stream("b2");
        check("b2_wrap", control_write_base, 32'h0);
        check("b2_bursts", 32'(bursts_done), 32'd2);
        check("b2_ovf_idle", 32'(overflow), 32'd1);

        // start_write drops after 5 words; stray done in STREAM.
        clear_logs();
        start_write = 1'b1;
        wait_ready();
        check("b3_ovf_clr", 32'(overflow), 32'd0);
        feed(5, 200);
        start_write  = 1'b0;
        control_done = 1'b1;
        feed(3, 205);
        control_done = 1'b0;
        check("b3_stray_done", 32'(bursts_done), 32'd2);
        check("b3_stray_base", control_write_base, 32'h0);
        feed(8, 208);
        check("b3_busy_wait", 32'(busy), 32'd1);
        finish_burst();
        step();
        check_stream("b3");
        check("b3_base", control_write_base, 32'h40);
        check("b3_bursts", 32'(bursts_done), 32'd3);
        check("b3_busy", 32'(busy), 32'd0);
        check("b3_go_n", 32'(go_q.size()), 32'd1);

        // Reset after word 7 abandons the burst.
        clear_logs();
        start_write = 1'b1;
        wait_ready();
        feed(7, 300);
        start_write  = 1'b0;
        sample_valid = 1'b1;
        sample_data  = 32'h999;
        reset        = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        step();
        step();
        sample_valid = 1'b0;
        check_stream("rb");
        check_reset_state("rb");

        // Three back-to-back bursts across the region wrap.
        clear_logs();
        start_write = 1'b1;
        for (int b = 0; b < 3; b++) begin
            wait_ready();
            feed(16, 400 + 16 * b);
            if (b == 2) start_write = 1'b0;
            finish_burst();
        end
        step();
        check_stream("wr");
        check("wr_go_n", 32'(go_q.size()), 32'd3);
        for (int i = 0; i < go_q.size() && i < 3; i++)
            check("wr_go_base", go_q[i], (i == 1) ? 32'h40 : 32'h0);
        check("wr_bursts", 32'(bursts_done), 32'd3);
        check("wr_base", control_write_base, 32'h40);
        check("wr_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
